// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multi-cycle RV32I core. Each instruction is walked
//   through FETCH / DECODE / EXEC / MEM / WB. Memory accesses wait on a
//   mem_ready handshake. Multiply/divide instructions can optionally stall in
//   MULWAIT for a fixed number of cycles. Illegal opcodes park the FSM in TRAP
//   until reset.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   opcode, funct7_0    instruction[6:0] and instruction[25] from the IR
//   mem_ready           memory completes the current access this cycle
//   pc_write, ir_write  PC / IR write enables
//   i_or_d              memory address select (0 = PC, 1 = ALU result)
//   jump                00 none, 01 JAL, 11 JALR
//   branch              conditional PC write (ANDed with ALU zero downstream)
//   mem_read, mem_write memory request strobes
//   mem_to_reg          writeback select (0 = ALU, 1 = memory)
//   alu_op, alu_src     ALU operation class and B-operand select
//   reg_write           register file write enable
//   instr_retired       one-cycle pulse when an instruction completes
//   illegal             sticky illegal-opcode flag
//   state               current FSM state, for debug
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter bit SUPPORT_MULDIV = 1'b1,
    parameter int MUL_LATENCY    = 4,
    parameter int CNT_W          = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       funct7_0,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic [1:0] jump,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       reg_write,
    output logic       instr_retired,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_MULWAIT = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR
    } op_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Counter preload: MULWAIT counts down to zero inclusive, so loading
    // MUL_LATENCY-1 gives exactly MUL_LATENCY cycles in that state.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

    state_t           state_q;
    op_t              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;

    op_t  dec_op;
    logic dec_legal;

    // Opcode classification, used only in DECODE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        dec_op    = OP_R;
        dec_legal = 1'b1;
        case (opcode)
            OPC_R:      dec_op = OP_R;
            OPC_I:      dec_op = OP_I;
            OPC_LOAD:   dec_op = OP_LOAD;
            OPC_STORE:  dec_op = OP_STORE;
            OPC_BRANCH: dec_op = OP_BRANCH;
            OPC_JALR:   dec_op = OP_JALR;
            OPC_JAL:    dec_op = OP_JAL;
            default:    dec_legal = 1'b0;
        endcase
    end

    // State register and sequencing.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= OP_R;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= dec_op;
                    if (dec_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: begin
                            if (SUPPORT_MULDIV && funct7_0) begin
                                cnt_q   <= CNT_LOAD;
                                state_q <= S_MULWAIT;
                            end else begin
                                state_q <= S_WB;
                            end
                        end
                        OP_LOAD, OP_STORE: state_q <= S_MEM;
                        OP_BRANCH:         state_q <= S_FETCH;
                        default:           state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) state_q <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
                end
                S_MULWAIT: begin
                    if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
                    else             state_q <= S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Control outputs decoded from the current state and latched class.
    // Reset forces everything low in the same cycle so a half-finished
    // access is dropped immediately.
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        jump          = 2'b00;
        branch        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_op        = 2'b00;
        alu_src       = 1'b0;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R:     alu_op = 2'b10;
                        OP_I:     begin alu_op = 2'b11; alu_src = 1'b1; end
                        OP_LOAD,
                        OP_STORE: alu_src = 1'b1;
                        OP_BRANCH: begin
                            alu_op        = 2'b01;
                            branch        = 1'b1;
                            instr_retired = 1'b1;
                        end
                        OP_JALR:  alu_src = 1'b1;
                        default:  alu_src = 1'b0;
                    endcase
                end
                S_MEM: begin
                    i_or_d        = 1'b1;
                    mem_read      = (op_q == OP_LOAD);
                    mem_write     = (op_q == OP_STORE);
                    instr_retired = (op_q == OP_STORE) && mem_ready;
                end
                S_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    mem_to_reg    = (op_q == OP_LOAD);
                    if (op_q == OP_JAL) begin
                        jump     = 2'b01;
                        pc_write = 1'b1;
                    end else if (op_q == OP_JALR) begin
                        jump     = 2'b11;
                        pc_write = 1'b1;
                    end
                end
                S_TRAP:  illegal = illegal_q;
                default: ;
            endcase
        end
    end

    assign state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. Two instances share the instruction
//   and mem_ready inputs: dut_a uses the default parameters, dut_b is built
//   with SUPPORT_MULDIV=0. Each has its own reset so one can be parked while
//   the other runs. Every cycle, the full output bundle is compared with a
//   hand-computed value at the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [6:0] opcode;
    logic       funct7_0;
    logic       mem_ready;

    // Bundle layout: {pc_write, ir_write, i_or_d, jump[1:0], branch, mem_read,
    //                 mem_write, mem_to_reg, alu_op[1:0], alu_src, reg_write,
    //                 instr_retired, illegal, state[2:0]}
    localparam logic [17:0] PCW    = 18'h1 << 17;
    localparam logic [17:0] IRW    = 18'h1 << 16;
    localparam logic [17:0] IOD    = 18'h1 << 15;
    localparam logic [17:0] J_JAL  = 18'h1 << 13;
    localparam logic [17:0] J_JALR = 18'h3 << 13;
    localparam logic [17:0] BR     = 18'h1 << 12;
    localparam logic [17:0] MR     = 18'h1 << 11;
    localparam logic [17:0] MW     = 18'h1 << 10;
    localparam logic [17:0] M2R    = 18'h1 << 9;
    localparam logic [17:0] A_BR   = 18'h1 << 7;
    localparam logic [17:0] A_R    = 18'h2 << 7;
    localparam logic [17:0] A_I    = 18'h3 << 7;
    localparam logic [17:0] SRC    = 18'h1 << 6;
    localparam logic [17:0] RW     = 18'h1 << 5;
    localparam logic [17:0] RET    = 18'h1 << 4;
    localparam logic [17:0] ILL    = 18'h1 << 3;
    localparam logic [17:0] ST_F = 18'd0, ST_D = 18'd1, ST_E = 18'd2, ST_M = 18'd3;
    localparam logic [17:0] ST_W = 18'd4, ST_MW = 18'd5, ST_T = 18'd6;

    logic       pc_write_a, ir_write_a, i_or_d_a, branch_a, mem_read_a, mem_write_a;
    logic       mem_to_reg_a, alu_src_a, reg_write_a, instr_retired_a, illegal_a;
    logic [1:0] jump_a, alu_op_a;
    logic [2:0] state_a;
    logic       pc_write_b, ir_write_b, i_or_d_b, branch_b, mem_read_b, mem_write_b;
    logic       mem_to_reg_b, alu_src_b, reg_write_b, instr_retired_b, illegal_b;
    logic [1:0] jump_b, alu_op_b;
    logic [2:0] state_b;

    multicycle_control dut_a (
        .clk(clk), .reset(reset_a), .opcode(opcode), .funct7_0(funct7_0),
        .mem_ready(mem_ready), .pc_write(pc_write_a), .ir_write(ir_write_a),
        .i_or_d(i_or_d_a), .jump(jump_a), .branch(branch_a), .mem_read(mem_read_a),
        .mem_write(mem_write_a), .mem_to_reg(mem_to_reg_a), .alu_op(alu_op_a),
        .alu_src(alu_src_a), .reg_write(reg_write_a), .instr_retired(instr_retired_a),
        .illegal(illegal_a), .state(state_a)
    );

    multicycle_control #(.SUPPORT_MULDIV(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .opcode(opcode), .funct7_0(funct7_0),
        .mem_ready(mem_ready), .pc_write(pc_write_b), .ir_write(ir_write_b),
        .i_or_d(i_or_d_b), .jump(jump_b), .branch(branch_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b), .alu_op(alu_op_b),
        .alu_src(alu_src_b), .reg_write(reg_write_b), .instr_retired(instr_retired_b),
        .illegal(illegal_b), .state(state_b)
    );

    wire [17:0] obs_a = {pc_write_a, ir_write_a, i_or_d_a, jump_a, branch_a, mem_read_a,
                         mem_write_a, mem_to_reg_a, alu_op_a, alu_src_a, reg_write_a,
                         instr_retired_a, illegal_a, state_a};
    wire [17:0] obs_b = {pc_write_b, ir_write_b, i_or_d_b, jump_b, branch_b, mem_read_b,
                         mem_write_b, mem_to_reg_b, alu_op_b, alu_src_b, reg_write_b,
                         instr_retired_b, illegal_b, state_b};

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply mem_ready, compare at the falling edge, then
    // advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic [17:0] exp,
                       input bit use_b);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, use_b ? obs_b : obs_a, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic f7);
        opcode   = opc;
        funct7_0 = f7;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        mem_ready = 1'b1;
        set_instr(7'b0110011, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc("reset_a", 1'b1, 18'd0, 1'b0);
        reset_a = 1'b0;

        // ADD: 4 cycles, retire only in WB.
        cyc("add_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("add_d", 1'b1, ST_D, 1'b0);
        cyc("add_e", 1'b1, A_R | ST_E, 1'b0);
        cyc("add_w", 1'b1, RW | RET | ST_W, 1'b0);

        // LW: one FETCH wait, then MEM held for three not-ready cycles.
        set_instr(7'b0000011, 1'b0);
        cyc("lw_f_wait", 1'b0, MR | ST_F, 1'b0);
        cyc("lw_f",      1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("lw_d",      1'b0, ST_D, 1'b0);
        cyc("lw_e",      1'b1, SRC | ST_E, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw_m_wait", 1'b0, IOD | MR | ST_M, 1'b0);
        cyc("lw_m",      1'b1, IOD | MR | ST_M, 1'b0);
        cyc("lw_w",      1'b1, RW | RET | M2R | ST_W, 1'b0);

        // SW then BEQ.
        set_instr(7'b0100011, 1'b0);
        cyc("sw_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("sw_d", 1'b1, ST_D, 1'b0);
        cyc("sw_e", 1'b1, SRC | ST_E, 1'b0);
        cyc("sw_m", 1'b1, IOD | MW | RET | ST_M, 1'b0);
        set_instr(7'b1100011, 1'b0);
        cyc("beq_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("beq_d", 1'b1, ST_D, 1'b0);
        cyc("beq_e", 1'b1, A_BR | BR | RET | ST_E, 1'b0);

        // I-type ALU.
        set_instr(7'b0010011, 1'b0);
        cyc("addi_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("addi_d", 1'b1, ST_D, 1'b0);
        cyc("addi_e", 1'b1, A_I | SRC | ST_E, 1'b0);
        cyc("addi_w", 1'b1, RW | RET | ST_W, 1'b0);

        // MUL: four MULWAIT cycles, WB in cycle 8.
        set_instr(7'b0110011, 1'b1);
        cyc("mul_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("mul_d", 1'b1, ST_D, 1'b0);
        cyc("mul_e", 1'b1, A_R | ST_E, 1'b0);
        for (int i = 0; i < 4; i++) cyc("mul_wait", 1'b1, ST_MW, 1'b0);
        cyc("mul_w", 1'b1, RW | RET | ST_W, 1'b0);

        // JALR and JAL.
        set_instr(7'b1100111, 1'b0);
        cyc("jalr_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("jalr_d", 1'b1, ST_D, 1'b0);
        cyc("jalr_e", 1'b1, SRC | ST_E, 1'b0);
        cyc("jalr_w", 1'b1, J_JALR | PCW | RW | RET | ST_W, 1'b0);
        set_instr(7'b1101111, 1'b0);
        cyc("jal_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("jal_d", 1'b1, ST_D, 1'b0);
        cyc("jal_e", 1'b1, ST_E, 1'b0);
        cyc("jal_w", 1'b1, J_JAL | PCW | RW | RET | ST_W, 1'b0);

        // Illegal opcode: TRAP held while opcode and mem_ready wiggle.
        set_instr(7'b1111111, 1'b0);
        cyc("ill_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("ill_d", 1'b1, ST_D, 1'b0);
        set_instr(7'b0110011, 1'b0);
        for (int i = 0; i < 22; i++) cyc("trap_hold", 1'(i % 2), ILL | ST_T, 1'b0);
        reset_a = 1'b1;
        cyc("trap_rst_same", 1'b1, 18'd0, 1'b0);
        cyc("trap_rst_next", 1'b1, 18'd0, 1'b0);
        reset_a = 1'b0;
        cyc("trap_after_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("trap_after_d", 1'b1, ST_D, 1'b0);
        cyc("trap_after_e", 1'b1, A_R | ST_E, 1'b0);
        cyc("trap_after_w", 1'b1, RW | RET | ST_W, 1'b0);

        // Reset in the middle of a load's MEM phase.
        set_instr(7'b0000011, 1'b0);
        cyc("abort_f", 1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("abort_d", 1'b1, ST_D, 1'b0);
        cyc("abort_e", 1'b1, SRC | ST_E, 1'b0);
        cyc("abort_m", 1'b0, IOD | MR | ST_M, 1'b0);
        cyc("abort_m", 1'b0, IOD | MR | ST_M, 1'b0);
        reset_a = 1'b1;
        cyc("abort_rst_same", 1'b1, 18'd0, 1'b0);
        cyc("abort_rst_next", 1'b1, 18'd0, 1'b0);
        reset_a = 1'b0;
        cyc("abort_fetch_wait", 1'b0, MR | ST_F, 1'b0);
        cyc("abort_fetch",      1'b1, PCW | IRW | MR | ST_F, 1'b0);
        cyc("abort_redecode",   1'b1, ST_D, 1'b0);

        // SUPPORT_MULDIV=0: MUL behaves as a plain R-type.
        reset_a = 1'b1;
        set_instr(7'b0110011, 1'b1);
        cyc("nomd_reset", 1'b1, 18'd0, 1'b1);
        reset_b = 1'b0;
        cyc("nomd_f", 1'b1, PCW | IRW | MR | ST_F, 1'b1);
        cyc("nomd_d", 1'b1, ST_D, 1'b1);
        cyc("nomd_e", 1'b1, A_R | ST_E, 1'b1);
        cyc("nomd_w", 1'b1, RW | RET | ST_W, 1'b1);
        cyc("nomd_next_f", 1'b1, PCW | IRW | MR | ST_F, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
